// File: rtl/sort_result_checker.sv
// sort_result_checker: snoops a sort batch, then checks the sorted stream for order, protocol and drain timeout.
// Define SORT_CHK_SIGNATURE_EN to add the sum/xor permutation signatures (err[2:1]).
module sort_result_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DATA   = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        out_valid,
  input  logic [DATA_WIDTH-1:0]       out_data,
  output logic                        busy,
  output logic                        check_done,
  output logic                        pass,
  output logic                        fail,
  output logic [4:0]                  err_code,
  output logic [$clog2(NUM_DATA):0]   mismatch_idx
);
  localparam int CW = $clog2(NUM_DATA) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, REPORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [4:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [1:0] sig_err;
`ifdef SORT_CHK_SIGNATURE_EN
  localparam int SW = DATA_WIDTH + $clog2(NUM_DATA);
  logic [SW-1:0] sum_in_q, sum_in_d, sum_out_q, sum_out_d;
  logic [DATA_WIDTH-1:0] xor_in_q, xor_in_d, xor_out_q, xor_out_d;
  always_comb begin
    sum_in_d = sum_in_q;
    xor_in_d = xor_in_q;
    sum_out_d = sum_out_q;
    xor_out_d = xor_out_q;
    if (state_q == IDLE && in_valid) begin
      sum_in_d = SW'(in_data);
      xor_in_d = in_data;
      sum_out_d = '0;
      xor_out_d = '0;
    end else if (state_q == LOAD && in_valid) begin
      sum_in_d = sum_in_q + SW'(in_data);
      xor_in_d = xor_in_q ^ in_data;
    end else if (state_q == DRAIN && out_valid) begin
      sum_out_d = sum_out_q + SW'(out_data);
      xor_out_d = xor_out_q ^ out_data;
    end
    sig_err = {xor_in_d != xor_out_d, sum_in_d != sum_out_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_in_q <= '0;
      sum_out_q <= '0;
      xor_in_q <= '0;
      xor_out_q <= '0;
    end else begin
      sum_in_q <= sum_in_d;
      sum_out_q <= sum_out_d;
      xor_in_q <= xor_in_d;
      xor_out_q <= xor_out_d;
    end
  end
`else
  assign sig_err = '0;
`endif
  always_comb begin
    state_d = state_q;
    in_cnt_d = in_cnt_q;
    out_cnt_d = out_cnt_q;
    idx_d = idx_q;
    idle_d = idle_q;
    prev_d = prev_q;
    err_d = err_q;
    done_d = 1'b0;
    pass_d = pass_q;
    fail_d = fail_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = LOAD;
        in_cnt_d = CW'(1);
        out_cnt_d = '0;
        idx_d = '0;
        err_d = '0;
        pass_d = 1'b0;
        fail_d = 1'b0;
      end
      LOAD: begin
        if (out_valid) err_d[3] = 1'b1;
        if (in_valid) begin
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q == CW'(NUM_DATA - 1)) begin
            state_d = DRAIN;
            idle_d = '0;
          end
        end
      end
      DRAIN: begin
        if (in_valid) err_d[3] = 1'b1;
        if (out_valid) begin
          out_cnt_d = out_cnt_q + CW'(1);
          prev_d = out_data;
          idle_d = '0;
          if (out_cnt_q != '0 && out_data < prev_q) begin
            idx_d = err_q[0] ? idx_q : out_cnt_q;
            err_d[0] = 1'b1;
          end
          if (out_cnt_q == CW'(NUM_DATA - 1)) state_d = REPORT;
        end else if (idle_q == TW'(TIMEOUT - 1)) begin
          err_d[4] = 1'b1;
          state_d = REPORT;
        end else begin
          idle_d = idle_q + TW'(1);
        end
        // verdict is registered on entry so it is visible during the REPORT cycle
        if (state_d == REPORT) begin
          err_d[2:1] = sig_err;
          done_d = 1'b1;
          pass_d = (err_d == '0);
          fail_d = (err_d != '0);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      idx_q <= '0;
      idle_q <= '0;
      prev_q <= '0;
      err_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      idx_q <= idx_d;
      idle_q <= idle_d;
      prev_q <= prev_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end
  assign busy = busy_q;
  assign check_done = done_q;
  assign pass = pass_q;
  assign fail = fail_q;
  assign err_code = err_q;
  assign mismatch_idx = idx_q;
endmodule

// File: tb/tb_sort_result_checker.sv
// tb_sort_result_checker: directed batches; verdicts queued by the driver, compared by a check_done monitor.
module tb_sort_result_checker;
  logic clk = 0, rst = 1, in_valid = 0, out_valid = 0;
  logic [7:0] in_data = 0, out_data = 0;
  logic busy, check_done, pass, fail;
  logic [4:0] err_code;
  logic [2:0] mismatch_idx;
  typedef struct packed {logic p; logic f; logic [4:0] e; logic [2:0] i;} exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0;
`ifdef SORT_CHK_SIGNATURE_EN
  localparam bit SIG = 1;
`else
  localparam bit SIG = 0;
`endif
  sort_result_checker #(.DATA_WIDTH(8), .NUM_DATA(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .check_done(check_done), .pass(pass), .fail(fail),
    .err_code(err_code), .mismatch_idx(mismatch_idx));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && check_done) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_verdict: got check_done=1 expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pass", pass, e.p);
        chk("fail", fail, e.f);
        chk("err_code", err_code, e.e);
        chk("mismatch_idx", mismatch_idx, e.i);
      end
    end
  end
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ov, input logic [7:0] od);
    @(negedge clk);
    in_valid = iv;
    in_data = id;
    out_valid = ov;
    out_data = od;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      cyc(0, 0, 0, 0);
      n++;
    end while (!check_done && n < 40);
    cyc(0, 0, 0, 0);
  endtask
  task automatic run(input logic [31:0] iw, input logic [31:0] ow, input int nout, input exp_t e);
    int n;
    q.push_back(e);
    for (int i = 0; i < 4; i++) cyc(1, iw[31-8*i -: 8], 0, 0);
    for (int i = 0; i < nout; i++) cyc(0, 0, 1, ow[31-8*i -: 8]);
    wait_done(n);
    if (nout == 4) chk("done_latency", n, 1);
    else chk("timeout_latency", n, 17);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_check_done"}, check_done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_idx"}, mismatch_idx, 0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("reset");
    run({8'd5, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd3, 8'd5, 8'd9}, 4, '{1, 0, 0, 0});
    repeat (3) cyc(0, 0, 0, 0);
    chk("pass_hold", pass, 1);
    chk("busy_idle", busy, 0);
    run({8'd5, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd5, 8'd3, 8'd9}, 4, '{0, 1, 5'd1, 3'd2});
    run({8'd5, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd3, 8'd5, 8'd8}, 4,
        '{!SIG, SIG, SIG ? 5'd6 : 5'd0, 3'd0});
    run({8'd7, 8'd7, 8'd2, 8'd2}, {8'd2, 8'd2, 8'd7, 8'd7}, 4, '{1, 0, 0, 0});
    q.push_back('{0, 1, 5'd8, 3'd0});
    cyc(1, 5, 0, 0);
    cyc(1, 3, 0, 0);
    chk("busy_load", busy, 1);
    cyc(0, 0, 1, 8'd7);
    cyc(1, 9, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 5);
    cyc(0, 0, 1, 9);
    wait_done(n);
    chk("protocol_latency", n, 1);
    run({8'd5, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd3, 8'd0, 8'd0}, 2,
        '{0, 1, SIG ? 5'd22 : 5'd16, 3'd0});
    for (int i = 0; i < 4; i++) cyc(1, 8'd10 + 8'(i), 0, 0);
    cyc(0, 0, 1, 8'd10);
    cyc(0, 0, 0, 0);
    chk("busy_drain", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_zero("mid_reset");
    run({8'd5, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd3, 8'd5, 8'd9}, 4, '{1, 0, 0, 0});
    repeat (5) cyc(0, 0, 0, 0);
    chk("pending_verdicts", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
